// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, stall lengths, FSM states.
package hazard_pkg;
   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   // Cycles a decode consumer must wait for a producer at each stage distance.
   localparam logic [1:0] STALL_EX  = 2'd3;
   localparam logic [1:0] STALL_MEM = 2'd2;
   localparam logic [1:0] STALL_WB  = 2'd1;

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/hazard_src_cmp.sv
// Per-source comparator: flags which in-flight destination (EX/MEM/WB) a decode source reads.
module hazard_src_cmp #(
   parameter int REG_AW  = 3,
   parameter int R0_ZERO = 0
) (
   input  logic [REG_AW-1:0] srcAddr,
   input  logic              srcValid,
   input  logic [REG_AW-1:0] exAddr,
   input  logic              exWrite,
   input  logic [REG_AW-1:0] memAddr,
   input  logic              memWrite,
   input  logic [REG_AW-1:0] wbAddr,
   input  logic              wbWrite,
   output logic              exMatch,
   output logic              memMatch,
   output logic              wbMatch
);
   logic live;

   // A hardwired-zero register is never produced, so it can never hazard.
   assign live     = srcValid && ((R0_ZERO == 0) || (srcAddr != '0));
   assign exMatch  = live && exWrite  && (srcAddr == exAddr);
   assign memMatch = live && memWrite && (srcAddr == memAddr);
   assign wbMatch  = live && wbWrite  && (srcAddr == wbAddr);
endmodule

// File: rtl/hazard_ctrl_gen.sv
// Decode-side hazard controller: RAW detection, counter-timed stall FSM, branch flush.
// Build option: define HAZARD_CTRL_FWD_EN for forwarding mode (only load-use stalls).
module hazard_ctrl_gen
   import hazard_pkg::*;
#(
   parameter int REG_AW    = 3,
   parameter int NUM_SRC   = 2,
   parameter int RF_BYPASS = 0,
   parameter int R0_ZERO   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]        id_src_valid,
   input  logic [REG_AW-1:0]         ex_wr_addr,
   input  logic [REG_AW-1:0]         mem_wr_addr,
   input  logic [REG_AW-1:0]         wb_wr_addr,
   input  logic                      ex_reg_write,
   input  logic                      mem_reg_write,
   input  logic                      wb_reg_write,
   input  logic                      ex_mem_read,
   input  logic                      branch_taken,
   output logic                      stall_pc,
   output logic                      stall_ifid,
   output logic                      bubble_idex,
   output logic                      flush_ifid,
   output logic                      flush_idex,
   output logic                      stall_start,
   output logic [1:0]                stall_cnt,
   output logic [NUM_SRC*2-1:0]      fwd_sel
);
   logic [NUM_SRC-1:0] exM, memM, wbM;
   logic [1:0]         req, cnt, cntCur, cntNext;
   state_t             state, stateNext;

   for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
      hazard_src_cmp #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) uCmp (
         .srcAddr  (id_src_addr[i*REG_AW +: REG_AW]),
         .srcValid (id_src_valid[i]),
         .exAddr   (ex_wr_addr),
         .exWrite  (ex_reg_write),
         .memAddr  (mem_wr_addr),
         .memWrite (mem_reg_write),
         .wbAddr   (wb_wr_addr),
         .wbWrite  (wb_reg_write),
         .exMatch  (exM[i]),
         .memMatch (memM[i]),
         .wbMatch  (wbM[i])
      );
   end

`ifdef HAZARD_CTRL_FWD_EN
   logic [NUM_SRC*2-1:0] fwdRaw;
   logic                 unusedFwd;

   assign unusedFwd = (^wbM) ^ (RF_BYPASS != 0);

   // Only a load in EX cannot be forwarded in time.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (exM[i] && ex_mem_read) req = STALL_WB;
   end

   // Youngest producer wins.
   always_comb begin
      fwdRaw = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (exM[i] && !ex_mem_read) fwdRaw[i*2 +: 2] = FWD_EXMEM;
         else if (memM[i])           fwdRaw[i*2 +: 2] = FWD_MEMWB;
      end
   end

   assign fwd_sel = (!rst || bubble_idex) ? '0 : fwdRaw;
`else
   logic unusedDist;

   assign unusedDist = ex_mem_read;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (exM[i])                        req = max2(req, STALL_EX);
         else if (memM[i])                  req = max2(req, STALL_MEM);
         else if (wbM[i] && RF_BYPASS == 0) req = max2(req, STALL_WB);
      end
   end

   assign fwd_sel = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // cntCur is the count shown this cycle; the register holds the next cycle's value.
   always_comb begin
      stateNext   = IDLE;
      cntNext     = '0;
      cntCur      = '0;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      stall_start = 1'b0;
      if (!rst) begin
         stateNext = IDLE;
      end else if (branch_taken) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else begin
         case (state)
            IDLE: if (req != '0) begin
               stall_start = 1'b1;
               stall_pc    = 1'b1;
               stall_ifid  = 1'b1;
               bubble_idex = 1'b1;
               cntCur      = req - 2'd1;
            end
            STALL: begin
               stall_pc    = 1'b1;
               stall_ifid  = 1'b1;
               bubble_idex = 1'b1;
               cntCur      = cnt;
            end
            default: stateNext = IDLE;
         endcase
         if (cntCur != '0) begin
            stateNext = STALL;
            cntNext   = cntCur - 2'd1;
         end
      end
      stall_cnt = cntCur;
   end
endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Scoreboard bench: directed vectors push expectations, a negedge monitor pops and compares.
// Three instances share inputs: default, RF_BYPASS=1 and R0_ZERO=1.
module tb_hazard_ctrl_gen;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] srcAddr;
   logic [1:0] srcValid;
   logic [2:0] exA, memA, wbA;
   logic       exW, memW, wbW, exRd, br;

   logic       stallPc, stallIfid, bubble, flI, flE, start;
   logic [1:0] cnt;
   logic [3:0] fwd;
   logic       bStallPc, bStallIfid, bBubble, bFlI, bFlE, bStart;
   logic [1:0] bCnt;
   logic [3:0] bFwd;
   logic       rStallPc, rStallIfid, rBubble, rFlI, rFlE, rStart;
   logic [1:0] rCnt;
   logic [3:0] rFwd;

   typedef struct packed {
      logic       stl;
      logic       fl;
      logic       st;
      logic [1:0] cnt;
      logic [3:0] fwd;
      logic       bStl;
      logic       rStl;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl_gen dut (
      .clk(clk), .rst(rst), .id_src_addr(srcAddr), .id_src_valid(srcValid),
      .ex_wr_addr(exA), .mem_wr_addr(memA), .wb_wr_addr(wbA),
      .ex_reg_write(exW), .mem_reg_write(memW), .wb_reg_write(wbW),
      .ex_mem_read(exRd), .branch_taken(br),
      .stall_pc(stallPc), .stall_ifid(stallIfid), .bubble_idex(bubble),
      .flush_ifid(flI), .flush_idex(flE), .stall_start(start),
      .stall_cnt(cnt), .fwd_sel(fwd));

   hazard_ctrl_gen #(.RF_BYPASS(1)) dutByp (
      .clk(clk), .rst(rst), .id_src_addr(srcAddr), .id_src_valid(srcValid),
      .ex_wr_addr(exA), .mem_wr_addr(memA), .wb_wr_addr(wbA),
      .ex_reg_write(exW), .mem_reg_write(memW), .wb_reg_write(wbW),
      .ex_mem_read(exRd), .branch_taken(br),
      .stall_pc(bStallPc), .stall_ifid(bStallIfid), .bubble_idex(bBubble),
      .flush_ifid(bFlI), .flush_idex(bFlE), .stall_start(bStart),
      .stall_cnt(bCnt), .fwd_sel(bFwd));

   hazard_ctrl_gen #(.R0_ZERO(1)) dutR0 (
      .clk(clk), .rst(rst), .id_src_addr(srcAddr), .id_src_valid(srcValid),
      .ex_wr_addr(exA), .mem_wr_addr(memA), .wb_wr_addr(wbA),
      .ex_reg_write(exW), .mem_reg_write(memW), .wb_reg_write(wbW),
      .ex_mem_read(exRd), .branch_taken(br),
      .stall_pc(rStallPc), .stall_ifid(rStallIfid), .bubble_idex(rBubble),
      .flush_ifid(rFlI), .flush_idex(rFlE), .stall_start(rStart),
      .stall_cnt(rCnt), .fwd_sel(rFwd));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("stall_pc",    stallPc,   e.stl);
         chk("stall_ifid",  stallIfid, e.stl);
         chk("bubble_idex", bubble,    e.stl);
         chk("flush_ifid",  flI,       e.fl);
         chk("flush_idex",  flE,       e.fl);
         chk("stall_start", start,     e.st);
         chk("stall_cnt",   cnt,       e.cnt);
         chk("fwd_sel",     fwd,       e.fwd);
         chk("byp_stall",   bStallPc,  e.bStl);
         chk("r0_stall",    rStallPc,  e.rStl);
      end
   end

   task automatic setIn(input int s0, v0, s1, v1, ea, ew, ma, mw, wa, ww, rd, b);
      srcAddr  = {3'(s1), 3'(s0)};
      srcValid = {1'(v1), 1'(v0)};
      exA = 3'(ea);  exW  = 1'(ew);
      memA = 3'(ma); memW = 1'(mw);
      wbA = 3'(wa);  wbW  = 1'(ww);
      exRd = 1'(rd); br   = 1'(b);
   endtask

   task automatic clr();
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cyc(input logic stl, fl, st, input logic [1:0] c, input logic [3:0] f,
                      input logic bs, rs);
      q.push_back('{stl, fl, st, c, f, bs, rs});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 2'd0, 4'd0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      clr();
      @(posedge clk);
      #1;
      // Reset holds every output low even with a hazard present.
      setIn(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
      idle();
      rst = 1'b1;
`ifdef HAZARD_CTRL_FWD_EN
      setIn(2, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);     // ALU producer in EX
      cyc(0, 0, 0, 2'd0, 4'b0001, 0, 0);
      setIn(2, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0);     // load in EX: one bubble
      cyc(1, 0, 1, 2'd0, 4'b0000, 1, 1);
      setIn(2, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);     // load now in MEM
      cyc(0, 0, 0, 2'd0, 4'b0010, 0, 0);
      setIn(0, 0, 7, 1, 7, 1, 7, 1, 0, 0, 0, 0);     // EX beats MEM for src1
      cyc(0, 0, 0, 2'd0, 4'b0100, 0, 0);
      setIn(0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 2'd0, 4'b1000, 0, 0);
      setIn(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);     // load to r0
      cyc(1, 0, 1, 2'd0, 4'b0000, 1, 0);
      clr();
      idle();
`else
      setIn(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);     // EX producer: 3 cycles
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 1);
      clr();
      cyc(1, 0, 0, 2'd1, 4'd0, 1, 1);
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      idle();
      setIn(3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);     // source not read
      idle();
      setIn(0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);     // MEM producer on src1
      cyc(1, 0, 1, 2'd1, 4'd0, 1, 1);
      clr();
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      idle();
      setIn(6, 1, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0);     // WB producer; bypass hides it
      cyc(1, 0, 1, 2'd0, 4'd0, 0, 1);
      clr();
      idle();
      setIn(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);     // branch in 2nd stall cycle
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 1);
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 2'd0, 4'd0, 0, 0);
      setIn(0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);     // fresh start proves IDLE
      cyc(1, 0, 1, 2'd1, 4'd0, 1, 1);
      clr();
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      idle();
      setIn(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);     // branch beats a new hazard
      cyc(0, 1, 0, 2'd0, 4'd0, 0, 0);
      clr();
      idle();
      setIn(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);     // r0 producer
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 0);
      clr();
      cyc(1, 0, 0, 2'd1, 4'd0, 1, 0);
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 0);
      idle();
      setIn(2, 1, 4, 1, 2, 1, 4, 1, 0, 0, 0, 0);     // EX + MEM on different sources
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 1);
      clr();
      cyc(1, 0, 0, 2'd1, 4'd0, 1, 1);
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      idle();
      setIn(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);     // same address on both sources, held
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 1);
      cyc(1, 0, 0, 2'd1, 4'd0, 1, 1);
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      clr();
      idle();
      setIn(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);     // reset mid-episode
      cyc(1, 0, 1, 2'd2, 4'd0, 1, 1);
      clr();
      rst = 1'b0;
      idle();
      rst = 1'b1;
      idle();
      setIn(0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 2'd1, 4'd0, 1, 1);
      clr();
      cyc(1, 0, 0, 2'd0, 4'd0, 1, 1);
      idle();
`endif
      @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl_gen.md
Name: hazard_ctrl_gen

Overview:
Parametrised next-generation hazard controller for the 5-stage pipeline; sits beside the decode stage.
Detects RAW hazards between NUM_SRC decode source registers and the EX, MEM and WB destinations.
Issues a counter-timed stall episode (PC/IFID hold plus IDEX bubble) and flushes IFID/IDEX on a taken branch.
Replaces the ad hoc flag-flop stall sequencing with an explicit FSM and down-counter.

Parameters:
REG_AW, 3, register address width
NUM_SRC, 2, decode source operands checked
RF_BYPASS, 0, 1 = register file writes through in the same cycle, so a WB match needs no stall
R0_ZERO, 0, 1 = address 0 is hardwired zero and never hazards

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
id_src_addr  in  NUM_SRC*REG_AW  decode source addresses; source i at [i*REG_AW +: REG_AW]
id_src_valid  in  NUM_SRC  source i actually read
ex_wr_addr / mem_wr_addr / wb_wr_addr  in  REG_AW each  destination address per stage
ex_reg_write / mem_reg_write / wb_reg_write  in  1 each  stage will write the register file
ex_mem_read  in  1  EX instruction is a load
branch_taken  in  1  redirect resolved this cycle
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IFID
bubble_idex  out  1  load NOP into IDEX
flush_ifid  out  1  squash IFID
flush_idex  out  1  squash IDEX
stall_start  out  1  first cycle of a stall episode
stall_cnt  out  2  remaining stall cycles after this one
fwd_sel  out  NUM_SRC*2  per source: 0 = RF, 1 = EX/MEM, 2 = MEM/WB

Behaviour:
- Stage match for source i: src_valid[i] & stage_reg_write & (addr equal), additionally gated by addr != 0 when R0_ZERO = 1.
- Required cycles req, without FWD_EN: the maximum over all sources of 3 (EX match), 2 (MEM match), or 1 (WB match). The WB term is 0 when RF_BYPASS = 1. No match gives req = 0.
- FSM states: IDLE, STALL. Counter cnt is 2 bits.
- In IDLE with req > 0 and no branch_taken:
  - assert stall_pc, stall_ifid, bubble_idex and stall_start this cycle;
  - load cnt = req-1;
  - next state is STALL if req > 1, else IDLE.
- In STALL: assert stall_pc, stall_ifid and bubble_idex; stall_start = 0; decrement cnt. Leave for IDLE on the cycle in which cnt == 0 is consumed. No re-detection occurs while in STALL.
- stall_cnt equals the cnt value for the current cycle: req-1 in the start cycle, the register value in STALL, 0 otherwise.
- branch_taken in any state:
  - flush_ifid = flush_idex = 1;
  - all stall outputs = 0;
  - next state IDLE, cnt = 0.
  - branch_taken has priority over both a new and an ongoing stall.
- All outputs are combinational from state, cnt and inputs.
- While rst = 0: all outputs 0. On the next edge: state IDLE, cnt 0. Reset mid-episode abandons the episode.
- Simultaneous EX and MEM matches on different sources take the maximum (3). Equal addresses on both sources produce one episode, not two.

Optional Feature:
Macro HAZARD_CTRL_FWD_EN.
- With the macro defined:
  - only a load-use hazard stalls: ex_mem_read & EX match gives req = 1; all other matches give req = 0;
  - fwd_sel[i] = 1 on an EX match (ex_reg_write & !ex_mem_read), else 2 on a MEM match, else 0. The youngest stage wins.
  - fwd_sel is forced to 0 in a bubble cycle.
- Without the macro: distance-based req as above; fwd_sel is tied to 0. The port is present in both builds.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF, FWD_EXMEM, FWD_MEMWB encodings;
  - STALL_EX = 3, STALL_MEM = 2, STALL_WB = 1;
  - state encoding IDLE = 0, STALL = 1.
- One sub-module, hazard_src_cmp: a per-source comparator producing the ex/mem/wb match bits. It is instantiated NUM_SRC times via generate.
- The FSM and counter live in the top module.

Test Plan:
- Default parameters, no FWD_EN. id_src0 = 3 valid, ex_wr_addr = 3, ex_reg_write = 1 -> stall_start 1 cycle 0; stall_pc high for exactly 3 cycles; stall_cnt 2,1,0; then 0.
- mem_wr_addr = 5 matches src1 only -> 2-cycle stall. wb match only -> 1 cycle; with RF_BYPASS = 1 -> 0 cycles.
- Branch_taken in the 2nd cycle of a 3-cycle stall -> flush_ifid = flush_idex = 1 that cycle, stall_pc = 0, state IDLE the next cycle.
- R0_ZERO = 1, src = 0, ex_wr_addr = 0 with reg_write -> no stall. R0_ZERO = 0 -> 3-cycle stall.
- FWD_EN: ALU producer in EX for src0 = 2 -> no stall, fwd_sel[1:0] = 1. Load producer -> 1 stall cycle, then fwd_sel = 2.
- rst low during STALL with cnt = 1 -> all outputs 0 immediately. After release, IDLE with stall_cnt = 0.
